// File: rtl/ranc_cfg_pkg.sv
// Shared configuration for the RANC parameter loader: FSM state type, default
// sizing constants and the core-sequencing helper.
package ranc_cfg_pkg;

  localparam int unsigned RANC_NUM_NEURONS = 256;
  localparam int unsigned RANC_DW          = 368;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } ranc_state_e;

  // Next core index after idx, stepping over the output-bus tile.
  // A result >= nc means no loadable core remains.
  function automatic int unsigned next_valid_core(input int unsigned idx,
                                                  input int unsigned nc,
                                                  input int unsigned output_core);
    int unsigned n;
    n = idx + 1;
    if (n == output_core) n = n + 1;
    if (n > nc) n = nc;
    return n;
  endfunction

endpackage

// File: rtl/ranc_xor_fold.sv
// Folds a DW-bit word into 16 bits by XOR of its 16-bit slices; the top slice
// is zero-padded when DW is not a multiple of 16.
module ranc_xor_fold #(
  parameter int unsigned DW = 368
) (
  input  logic [DW-1:0] data_i,
  output logic [15:0]   fold_o
);

  localparam int unsigned LANES = (DW + 15) / 16;

  logic [LANES*16-1:0] padded;

  always_comb begin
    padded         = '0;
    padded[DW-1:0] = data_i;
    fold_o         = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      fold_o = fold_o ^ padded[i*16 +: 16];
    end
  end

endmodule

// File: rtl/ranc_param_dispatcher.sv
// Parameter/neuron-data loader for an X*Y RANC grid: sequences cores in address
// order, skips the output-bus tile, flags sequencing errors.
// Optional per-core checksum enabled by defining RANC_PARAM_CHECKSUM_EN.
module ranc_param_dispatcher
  import ranc_cfg_pkg::*;
#(
  parameter  int unsigned GRID_X      = 3,
  parameter  int unsigned GRID_Y      = 2,
  parameter  int unsigned OUTPUT_CORE = 5,
  parameter  int unsigned NUM_NEURONS = RANC_NUM_NEURONS,
  parameter  int unsigned DW          = RANC_DW,
  localparam int unsigned NC          = GRID_X * GRID_Y,
  localparam int unsigned AW          = $clog2(NUM_NEURONS),
  localparam int unsigned CW          = (NC > 1) ? $clog2(NC) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          in_wen,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_data,
  output logic [NC-1:0] param_wen,
  output logic [AW-1:0] param_addr,
  output logic [DW-1:0] param_data,
  output logic [CW-1:0] core_idx,
  output logic          core_done,
  output logic          busy,
  output logic          done,
  output logic          seq_error,
  output logic [15:0]   checksum
);

  localparam int unsigned   FIRST_CORE = (OUTPUT_CORE == 0) ? 1 : 0;
  localparam logic [AW-1:0] LAST_ADDR  = AW'(NUM_NEURONS - 1);
  localparam logic [NC-1:0] OUT_MASK   = (OUTPUT_CORE < NC) ? (NC'(1) << OUTPUT_CORE) : '0;

  ranc_state_e   state_q, state_d;
  logic [CW-1:0] core_idx_q, core_idx_d;
  logic [AW-1:0] exp_addr_q, exp_addr_d;
  logic [NC-1:0] wen_q, wen_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          core_done_q, core_done_d;
  logic          err_q, err_d;
  logic          accept;
  int unsigned   nxt;

  assign accept = (state_q == LOAD) && in_wen && (in_addr == exp_addr_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      core_idx_q  <= CW'(FIRST_CORE);
      exp_addr_q  <= '0;
      wen_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      core_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      core_idx_q  <= core_idx_d;
      exp_addr_q  <= exp_addr_d;
      wen_q       <= wen_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      core_done_q <= core_done_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    core_idx_d  = core_idx_q;
    exp_addr_d  = exp_addr_q;
    wen_d       = '0;
    addr_d      = addr_q;
    data_d      = data_q;
    core_done_d = 1'b0;
    err_d       = err_q;
    nxt         = 0;
    unique case (state_q)
      IDLE, DONE: begin
        if (in_wen) err_d = 1'b1;
        if (start) begin
          state_d    = LOAD;
          core_idx_d = CW'(FIRST_CORE);
          exp_addr_d = '0;
        end
      end
      LOAD: begin
        if (accept) begin
          wen_d[core_idx_q] = 1'b1;
          addr_d            = in_addr;
          data_d            = in_data;
          if (exp_addr_q == LAST_ADDR) begin
            core_done_d = 1'b1;
            exp_addr_d  = '0;
            nxt         = next_valid_core(int'(core_idx_q), NC, OUTPUT_CORE);
            if (nxt >= NC) state_d = DONE;
            else           core_idx_d = CW'(nxt);
          end else begin
            exp_addr_d = exp_addr_q + 1'b1;
          end
        end else if (in_wen) begin
          err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // The output tile never receives writes, whatever core_idx holds.
    wen_d = wen_d & ~OUT_MASK;
  end

  assign param_wen  = wen_q;
  assign param_addr = addr_q;
  assign param_data = data_q;
  assign core_idx   = core_idx_q;
  assign core_done  = core_done_q;
  assign busy       = (state_q == LOAD);
  assign done       = (state_q == DONE);
  assign seq_error  = err_q;

`ifdef RANC_PARAM_CHECKSUM_EN
  logic [15:0] fold;
  logic [15:0] checksum_q;

  ranc_xor_fold #(.DW(DW)) u_fold (
    .data_i (in_data),
    .fold_o (fold)
  );

  // The first accepted write of each core reseeds the running XOR.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    checksum_q <= '0;
    else if (accept) checksum_q <= (exp_addr_q == '0) ? fold : (checksum_q ^ fold);
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_ranc_param_dispatcher.sv
// Self-checking bench for ranc_param_dispatcher: scoreboarded writes, a vector
// table for address sequencing, and hand sequences for reset/stray corners.
module tb_ranc_param_dispatcher;

  localparam int unsigned DW    = 368;
  localparam int unsigned AW    = 8;
  localparam int unsigned NC    = 6;
  localparam int unsigned NN    = 256;
  localparam int unsigned LANES = (DW + 15) / 16;
  localparam int unsigned NC2   = 4;

  typedef struct {
    int unsigned   core;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  typedef struct {
    bit          st;
    bit          wen;
    int unsigned addr;
    bit          acc;
    bit          err;
    bit          busy;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start, in_wen;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic [NC-1:0] param_wen;
  logic [AW-1:0] param_addr;
  logic [DW-1:0] param_data;
  logic [2:0]    core_idx;
  logic          core_done, busy, done, seq_error;
  logic [15:0]   checksum;

  logic           start2, wen2;
  logic [AW-1:0]  addr2;
  logic [DW-1:0]  data2;
  logic [NC2-1:0] param_wen2;
  logic [AW-1:0]  param_addr2;
  logic [DW-1:0]  param_data2;
  logic [1:0]     core_idx2;
  logic           core_done2, busy2, done2, seq_error2;
  logic [15:0]    checksum2;

  exp_t        sbq[$];
  exp_t        mon_e;
  vec_t        tv[7];
  int unsigned tests = 0, fails = 0;
  int unsigned wen_cnt[NC];
  int unsigned wen2_cnt[NC2];
  int unsigned done_cnt;
  logic [15:0] csum_model;

  always #5 clk = ~clk;

  ranc_param_dispatcher #(.GRID_X(3), .GRID_Y(2), .OUTPUT_CORE(5), .NUM_NEURONS(NN), .DW(DW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .in_wen(in_wen), .in_addr(in_addr),
    .in_data(in_data), .param_wen(param_wen), .param_addr(param_addr), .param_data(param_data),
    .core_idx(core_idx), .core_done(core_done), .busy(busy), .done(done),
    .seq_error(seq_error), .checksum(checksum)
  );

  ranc_param_dispatcher #(.GRID_X(2), .GRID_Y(2), .OUTPUT_CORE(0), .NUM_NEURONS(NN), .DW(DW)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .in_wen(wen2), .in_addr(addr2),
    .in_data(data2), .param_wen(param_wen2), .param_addr(param_addr2), .param_data(param_data2),
    .core_idx(core_idx2), .core_done(core_done2), .busy(busy2), .done(done2),
    .seq_error(seq_error2), .checksum(checksum2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Each 16-bit lane carries {core, index}, so data differs per core and entry.
  function automatic logic [DW-1:0] mkdata(input int unsigned core, input int unsigned idx);
    logic [DW-1:0] d;
    d = '0;
    for (int unsigned i = 0; i < DW / 16; i++) d[i*16 +: 16] = {8'(core), 8'(idx)};
    return d;
  endfunction

  function automatic logic [15:0] fold16(input logic [DW-1:0] d);
    logic [LANES*16-1:0] p;
    logic [15:0] r;
    p = '0;
    p[DW-1:0] = d;
    r = '0;
    for (int unsigned i = 0; i < LANES; i++) r = r ^ p[i*16 +: 16];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int unsigned core, input int unsigned addr, input bit acc);
    in_wen  = 1'b1;
    in_addr = AW'(addr);
    in_data = mkdata(core, addr);
    if (acc) sbq.push_back('{core, AW'(addr), mkdata(core, addr), addr == NN - 1});
    tick();
    in_wen = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < NC; i++) wen_cnt[i] = 0;
  endtask

  task automatic drain();
    @(negedge clk);
    #1;
    check("scoreboard_empty", 64'(sbq.size()), 0);
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (core_done) done_cnt++;
      if (param_wen != '0) begin
        for (int i = 0; i < NC; i++) wen_cnt[i] += 32'(param_wen[i]);
        if (sbq.size() == 0) begin
          check("unexpected_wen", 64'(param_wen), 0);
        end else begin
          mon_e = sbq.pop_front();
          check("wen_core", 64'(param_wen), 64'(NC'(1) << mon_e.core));
          check("wen_addr", 64'(param_addr), 64'(mon_e.addr));
          check("wen_data_eq", 64'(param_data == mon_e.data), 1);
          check("core_done_pulse", 64'(core_done), 64'(mon_e.last));
          csum_model = (mon_e.addr == '0) ? fold16(mon_e.data) : (csum_model ^ fold16(mon_e.data));
`ifdef RANC_PARAM_CHECKSUM_EN
          if (core_done) check("checksum", 64'(checksum), 64'(csum_model));
`else
          if (core_done) check("checksum_off", 64'(checksum), 0);
`endif
        end
      end else if (core_done) begin
        check("stray_core_done", 64'(core_done), 0);
      end
      if (param_wen2 != '0) begin
        check("dut2_onehot", 64'($countones(param_wen2)), 1);
        for (int i = 0; i < NC2; i++) wen2_cnt[i] += 32'(param_wen2[i]);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] %0d tests run, %0d failed", tests, fails + 1);
  end

  initial begin
    tv[0] = '{1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1};
    tv[1] = '{1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b1};
    tv[2] = '{1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b1};
    tv[3] = '{1'b0, 1'b1, 3, 1'b0, 1'b1, 1'b1};
    tv[4] = '{1'b0, 1'b1, 2, 1'b1, 1'b1, 1'b1};
    tv[5] = '{1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b1};
    tv[6] = '{1'b0, 1'b1, 3, 1'b1, 1'b1, 1'b1};

    reset_n = 1'b0; start = 1'b0; in_wen = 1'b0; in_addr = '0; in_data = '0;
    start2 = 1'b0; wen2 = 1'b0; addr2 = '0; data2 = '0;
    csum_model = '0;
    for (int i = 0; i < NC2; i++) wen2_cnt[i] = 0;
    tick(); tick();

    // Reset state
    check("rst_wen", 64'(param_wen), 0);
    check("rst_core_idx", 64'(core_idx), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_err", 64'(seq_error), 0);
    check("rst_core_done", 64'(core_done), 0);
    check("rst_addr", 64'(param_addr), 0);
    check("rst_checksum", 64'(checksum), 0);
    check("rst_core_idx2", 64'(core_idx2), 1);
    do_reset();

    // Full load at full rate
    pulse_start();
    check("load_busy", 64'(busy), 1);
    for (int c = 0; c < 5; c++) begin
      for (int a = 0; a < NN; a++) begin
        if (c == 4 && a == NN - 1) check("done_not_early", 64'(done), 0);
        wr(c, a, 1'b1);
      end
    end
    check("full_done", 64'(done), 1);
    check("full_busy", 64'(busy), 0);
    drain();
    for (int c = 0; c < NC; c++) check($sformatf("full_cnt_core%0d", c), 64'(wen_cnt[c]), (c < 5) ? 64'(NN) : 0);
    check("full_core_done_cnt", 64'(done_cnt), 5);
    check("full_err", 64'(seq_error), 0);

    // Second instance: output tile at index 0, four cores
    start2 = 1'b1; tick(); start2 = 1'b0;
    for (int c = 1; c < NC2; c++) begin
      for (int a = 0; a < NN; a++) begin
        wen2 = 1'b1; addr2 = AW'(a); data2 = mkdata(c, a);
        tick();
      end
    end
    wen2 = 1'b0;
    @(negedge clk); #1;
    for (int c = 0; c < NC2; c++) check($sformatf("oc0_cnt_core%0d", c), 64'(wen2_cnt[c]), (c == 0) ? 0 : 64'(NN));
    check("oc0_done", 64'(done2), 1);
    check("oc0_err", 64'(seq_error2), 0);

    // Reset in the middle of core 2
    do_reset();
    pulse_start();
    for (int c = 0; c < 2; c++) for (int a = 0; a < NN; a++) wr(c, a, 1'b1);
    for (int a = 0; a < 100; a++) wr(2, a, 1'b1);
    check("mid_core_idx", 64'(core_idx), 2);
    @(negedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("midrst_wen", 64'(param_wen), 0);
    check("midrst_core_idx", 64'(core_idx), 0);
    check("midrst_busy", 64'(busy), 0);
    check("midrst_addr", 64'(param_addr), 0);
    tick();
    reset_n = 1'b1;
    pulse_start();
    wr(0, 0, 1'b1);
    wr(0, 1, 1'b1);
    check("restart_core_idx", 64'(core_idx), 0);
    drain();

    // Stray write in IDLE, then a normal load
    do_reset();
    wr(0, 0, 1'b0);
    check("idle_stray_err", 64'(seq_error), 1);
    check("idle_stray_busy", 64'(busy), 0);
    pulse_start();
    wr(0, 0, 1'b1);
    check("after_stray_busy", 64'(busy), 1);
    drain();

    // Address sequencing vectors
    do_reset();
    for (int i = 0; i < 7; i++) begin
      start   = tv[i].st;
      in_wen  = tv[i].wen;
      in_addr = AW'(tv[i].addr);
      in_data = mkdata(0, tv[i].addr);
      if (tv[i].acc) sbq.push_back('{0, AW'(tv[i].addr), mkdata(0, tv[i].addr), 1'b0});
      tick();
      start = 1'b0; in_wen = 1'b0;
      check($sformatf("vec%0d_err", i), 64'(seq_error), 64'(tv[i].err));
      check($sformatf("vec%0d_busy", i), 64'(busy), 64'(tv[i].busy));
    end
    for (int a = 4; a < NN; a++) wr(0, a, 1'b1);
    for (int c = 1; c < 5; c++) for (int a = 0; a < NN; a++) wr(c, a, 1'b1);
    check("vec_done", 64'(done), 1);

    // Stray write in DONE, then restart
    wr(0, 0, 1'b0);
    check("done_stray_done", 64'(done), 1);
    check("done_stray_err", 64'(seq_error), 1);
    pulse_start();
    wr(0, 0, 1'b1);
    check("restart_busy", 64'(busy), 1);
    check("restart_err_sticky", 64'(seq_error), 1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
